// File: rtl/sample_sched_pkg.sv
// Shared types and helpers for the multi-channel sample strobe scheduler.
package sample_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN
    } state_t;

    localparam int DEFAULT_CNT_W = 32;
    localparam int MAX_CH        = 16;
    localparam int MAX_CNT_W     = 64;
    localparam int PERIOD_FLAT_W = MAX_CH * MAX_CNT_W;

    // Returns channel ch's period slice, zero-extended to MAX_CNT_W bits.
    function automatic logic [MAX_CNT_W-1:0] period_slice(
        input logic [PERIOD_FLAT_W-1:0] flat,
        input int                       ch,
        input int                       cnt_w
    );
        logic [PERIOD_FLAT_W-1:0] shifted;
        logic [MAX_CNT_W-1:0]     mask;
        shifted = flat >> (ch * cnt_w);
        mask    = (cnt_w >= MAX_CNT_W) ? '1
                : ((MAX_CNT_W'(1) << cnt_w) - MAX_CNT_W'(1));
        return shifted[MAX_CNT_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/sample_sched_if.sv
// Control/status bundle between the scheduler and its host.
interface sample_sched_if
    import sample_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = DEFAULT_CNT_W
);
    logic                      run;
    logic [NUM_CH-1:0]         ch_en;
    logic [NUM_CH-1:0]         oneshot;
    logic [NUM_CH*CNT_W-1:0]   period;
    logic [NUM_CH-1:0]         sample_busy;
    logic                      ovr_clr;
    logic [NUM_CH-1:0]         sample_en;
    logic [NUM_CH-1:0]         overrun;
    logic                      warm;

    modport master (
        output run, ch_en, oneshot, period, sample_busy, ovr_clr,
        input  sample_en, overrun, warm
    );

    modport slave (
        input  run, ch_en, oneshot, period, sample_busy, ovr_clr,
        output sample_en, overrun, warm
    );
endinterface

// File: rtl/sample_sched_ch.sv
// One strobe channel: period counter, latched period, one-shot and overrun state.
module sample_sched_ch
    import sample_sched_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run_active,
    input  logic             arm,
    input  logic             ch_en,
    input  logic             oneshot,
    input  logic [CNT_W-1:0] period,
    input  logic             sample_busy,
    input  logic             ovr_clr,
    output logic             sample_en,
    output logic             overrun
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] p_q;
    logic [CNT_W-1:0] p_eff;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_inc;
    logic             done_q;
    logic             active;
    logic             load;
    logic             fire_next;

    // The period is (re)sampled on arm, in every fire cycle, and while idle at zero.
    always_comb begin
        active    = run_active && ch_en && !done_q;
        load      = arm || sample_en || (p_q == '0);
        p_eff     = load ? period : p_q;
        cnt_base  = load ? '0 : cnt_q;
        cnt_inc   = cnt_base + CNT_W'(1);
        fire_next = active && (p_eff != '0) && (cnt_inc == p_eff);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q     <= '0;
            p_q       <= '0;
            done_q    <= 1'b0;
            sample_en <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (!active) begin
                cnt_q     <= '0;
                p_q       <= '0;
                sample_en <= 1'b0;
            end else begin
                p_q       <= p_eff;
                cnt_q     <= (fire_next || (p_eff == '0)) ? '0 : cnt_inc;
                sample_en <= fire_next;
            end

            if (!run_active || !ch_en) begin
                done_q <= 1'b0;
            end else if (fire_next && oneshot) begin
                done_q <= 1'b1;
            end

            // A new overrun beats a simultaneous clear.
            if (sample_en && sample_busy) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sample_sched.sv
// Multi-channel sample strobe scheduler: global warm-up FSM plus NUM_CH strobe channels.
module sample_sched
    import sample_sched_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int STARTUP_CYC = 20000000
) (
    input  logic            clk_in,
    input  logic            rst,
    sample_sched_if.slave   bus
);

    localparam logic [CNT_W-1:0] WARM_LAST =
        CNT_W'((STARTUP_CYC > 0) ? (STARTUP_CYC - 1) : 0);

    state_t                   state;
    state_t                   state_next;
    logic [CNT_W-1:0]         warm_cnt;
    logic [CNT_W-1:0]         warm_cnt_next;
    logic                     in_run_q;
    logic                     run_active;
    logic                     first_run;
    logic [NUM_CH-1:0]        ch_en_q;
    logic [NUM_CH-1:0]        arm;
    logic [NUM_CH-1:0]        sample_en_w;
    logic [NUM_CH-1:0]        overrun_w;
    logic [PERIOD_FLAT_W-1:0] period_flat;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= IDLE;
            warm_cnt <= '0;
            in_run_q <= 1'b0;
            ch_en_q  <= '0;
        end else begin
            state    <= state_next;
            warm_cnt <= warm_cnt_next;
            in_run_q <= (state == RUN);
            ch_en_q  <= bus.ch_en;
        end
    end

    always_comb begin
        state_next    = state;
        warm_cnt_next = '0;
        case (state)
            IDLE: begin
                if (bus.run) begin
                    state_next = (STARTUP_CYC > 0) ? WARMUP : RUN;
                end
            end
            WARMUP: begin
                if (!bus.run) begin
                    state_next = IDLE;
                end else if (warm_cnt == WARM_LAST) begin
                    state_next = RUN;
                end else begin
                    warm_cnt_next = warm_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!bus.run) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Dropping run silences channels in the same cycle so no strobe leaks into IDLE.
    always_comb begin
        run_active  = (state == RUN) && bus.run;
        first_run   = (state == RUN) && !in_run_q;
        arm         = {NUM_CH{run_active}} & bus.ch_en & ({NUM_CH{first_run}} | ~ch_en_q);
        period_flat = '0;
        period_flat[NUM_CH*CNT_W-1:0] = bus.period;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sample_sched_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_in      (clk_in),
            .rst         (rst),
            .run_active  (run_active),
            .arm         (arm[i]),
            .ch_en       (bus.ch_en[i]),
            .oneshot     (bus.oneshot[i]),
            .period      (CNT_W'(period_slice(period_flat, i, CNT_W))),
            .sample_busy (bus.sample_busy[i]),
            .ovr_clr     (bus.ovr_clr),
            .sample_en   (sample_en_w[i]),
            .overrun     (overrun_w[i])
        );
    end

    assign bus.sample_en = sample_en_w;
    assign bus.overrun   = overrun_w;
    assign bus.warm      = (state == RUN);

endmodule
